// File: rtl/alu_design.sv
// Registered arithmetic/logic unit: one-cycle latency result and status flags,
// with operand-validity and illegal-command error reporting.
module alu_design #(
  parameter int unsigned WIDTH_O = 8,
  parameter int unsigned WIDTH_C = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic [WIDTH_C-1:0]   CMD,
  input  logic [1:0]           INP_VALID,
  input  logic [WIDTH_O-1:0]   OPA_1,
  input  logic [WIDTH_O-1:0]   OPB_1,
  input  logic                 CIN,
  output logic [2*WIDTH_O:0]   RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 E,
  output logic                 L,
  output logic                 ERR
);

  localparam int unsigned RW  = 2*WIDTH_O + 1;
  localparam int unsigned EW  = WIDTH_O + 1;
  localparam int unsigned SHW = (WIDTH_O > 1) ? $clog2(WIDTH_O) : 1;

  localparam logic [WIDTH_C-1:0] A_ADD     = WIDTH_C'(0);
  localparam logic [WIDTH_C-1:0] A_SUB     = WIDTH_C'(1);
  localparam logic [WIDTH_C-1:0] A_ADD_CIN = WIDTH_C'(2);
  localparam logic [WIDTH_C-1:0] A_SUB_CIN = WIDTH_C'(3);
  localparam logic [WIDTH_C-1:0] A_INC_A   = WIDTH_C'(4);
  localparam logic [WIDTH_C-1:0] A_DEC_A   = WIDTH_C'(5);
  localparam logic [WIDTH_C-1:0] A_INC_B   = WIDTH_C'(6);
  localparam logic [WIDTH_C-1:0] A_DEC_B   = WIDTH_C'(7);
  localparam logic [WIDTH_C-1:0] A_CMP     = WIDTH_C'(8);
  localparam logic [WIDTH_C-1:0] A_MUL_INC = WIDTH_C'(9);
  localparam logic [WIDTH_C-1:0] A_MUL_SHL = WIDTH_C'(10);
  localparam logic [WIDTH_C-1:0] A_SADD    = WIDTH_C'(11);
  localparam logic [WIDTH_C-1:0] A_SSUB    = WIDTH_C'(12);

  localparam logic [WIDTH_C-1:0] L_AND     = WIDTH_C'(0);
  localparam logic [WIDTH_C-1:0] L_NAND    = WIDTH_C'(1);
  localparam logic [WIDTH_C-1:0] L_OR      = WIDTH_C'(2);
  localparam logic [WIDTH_C-1:0] L_NOR     = WIDTH_C'(3);
  localparam logic [WIDTH_C-1:0] L_XOR     = WIDTH_C'(4);
  localparam logic [WIDTH_C-1:0] L_XNOR    = WIDTH_C'(5);
  localparam logic [WIDTH_C-1:0] L_NOT_A   = WIDTH_C'(6);
  localparam logic [WIDTH_C-1:0] L_NOT_B   = WIDTH_C'(7);
  localparam logic [WIDTH_C-1:0] L_SHR1_A  = WIDTH_C'(8);
  localparam logic [WIDTH_C-1:0] L_SHL1_A  = WIDTH_C'(9);
  localparam logic [WIDTH_C-1:0] L_SHR1_B  = WIDTH_C'(10);
  localparam logic [WIDTH_C-1:0] L_SHL1_B  = WIDTH_C'(11);
  localparam logic [WIDTH_C-1:0] L_ROL     = WIDTH_C'(12);
  localparam logic [WIDTH_C-1:0] L_ROR     = WIDTH_C'(13);

  logic [RW-1:0]      res_d, res_q;
  logic               cout_d, cout_q;
  logic               oflow_d, oflow_q;
  logic               g_d, g_q;
  logic               e_d, e_q;
  logic               l_d, l_q;
  logic               err_d, err_q;

  logic [EW-1:0]      a_e, b_e, as_e, bs_e, tmp_e, ss_e;
  logic [RW-1:0]      ainc_w, binc_w, ash_w;
  logic [SHW-1:0]     amt;
  logic [WIDTH_O-1:0] rol_r, ror_r, log_r;
  logic               need_a, need_b, bad_cmd, rot_err;

  // Operand views: zero-extended, sign-extended, and widened multiplier terms.
  assign a_e    = {1'b0, OPA_1};
  assign b_e    = {1'b0, OPB_1};
  assign as_e   = {OPA_1[WIDTH_O-1], OPA_1};
  assign bs_e   = {OPB_1[WIDTH_O-1], OPB_1};
  assign ainc_w = RW'(a_e) + RW'(1);
  assign binc_w = RW'(b_e) + RW'(1);
  assign ash_w  = RW'({OPA_1, 1'b0});
  assign amt    = OPB_1[SHW-1:0];

  // Rotations of A by the low bits of B.
  always_comb begin
    rol_r = '0;
    ror_r = '0;
    for (int i = 0; i < int'(WIDTH_O); i++) begin
      rol_r[i] = OPA_1[SHW'((i + int'(WIDTH_O) - int'(amt)) % int'(WIDTH_O))];
      ror_r[i] = OPA_1[SHW'((i + int'(amt)) % int'(WIDTH_O))];
    end
  end

  always_comb begin
    res_d   = '0;
    cout_d  = 1'b0;
    oflow_d = 1'b0;
    g_d     = 1'b0;
    e_d     = 1'b0;
    l_d     = 1'b0;
    err_d   = 1'b0;
    need_a  = 1'b0;
    need_b  = 1'b0;
    bad_cmd = 1'b0;
    rot_err = 1'b0;
    tmp_e   = '0;
    ss_e    = '0;
    log_r   = '0;

    if (MODE) begin
      case (CMD)
        A_ADD: begin
          need_a = 1'b1; need_b = 1'b1;
          tmp_e  = a_e + b_e;
          res_d  = RW'(tmp_e);
          cout_d = tmp_e[WIDTH_O];
        end
        A_SUB: begin
          need_a  = 1'b1; need_b = 1'b1;
          tmp_e   = a_e - b_e;
          res_d   = RW'(tmp_e);
          oflow_d = (OPA_1 < OPB_1);
        end
        A_ADD_CIN: begin
          need_a = 1'b1; need_b = 1'b1;
          tmp_e  = a_e + b_e + EW'(CIN);
          res_d  = RW'(tmp_e);
          cout_d = tmp_e[WIDTH_O];
        end
        A_SUB_CIN: begin
          need_a  = 1'b1; need_b = 1'b1;
          tmp_e   = a_e - b_e - EW'(CIN);
          res_d   = RW'(tmp_e);
          oflow_d = (a_e < (b_e + EW'(CIN)));
        end
        A_INC_A: begin
          need_a = 1'b1;
          tmp_e  = a_e + EW'(1);
          res_d  = RW'(tmp_e);
        end
        A_DEC_A: begin
          need_a = 1'b1;
          tmp_e  = a_e - EW'(1);
          res_d  = RW'(tmp_e);
        end
        A_INC_B: begin
          need_b = 1'b1;
          tmp_e  = b_e + EW'(1);
          res_d  = RW'(tmp_e);
        end
        A_DEC_B: begin
          need_b = 1'b1;
          tmp_e  = b_e - EW'(1);
          res_d  = RW'(tmp_e);
        end
        A_CMP: begin
          need_a = 1'b1; need_b = 1'b1;
          g_d    = (OPA_1 > OPB_1);
          e_d    = (OPA_1 == OPB_1);
          l_d    = (OPA_1 < OPB_1);
        end
        A_MUL_INC: begin
          need_a = 1'b1; need_b = 1'b1;
          res_d  = ainc_w * binc_w;
        end
        A_MUL_SHL: begin
          need_a = 1'b1; need_b = 1'b1;
          res_d  = ash_w * RW'(b_e);
        end
        A_SADD, A_SSUB: begin
          need_a  = 1'b1; need_b = 1'b1;
          ss_e    = (CMD == A_SADD) ? (as_e + bs_e) : (as_e - bs_e);
          res_d   = {{(RW-EW){ss_e[WIDTH_O]}}, ss_e};
          // n-bit overflow shows as disagreement between the two top sum bits
          oflow_d = ss_e[WIDTH_O] ^ ss_e[WIDTH_O-1];
          g_d     = ($signed(OPA_1) >  $signed(OPB_1));
          e_d     = (OPA_1 == OPB_1);
          l_d     = ($signed(OPA_1) <  $signed(OPB_1));
        end
        default: bad_cmd = 1'b1;
      endcase
    end else begin
      case (CMD)
        L_AND:    begin need_a = 1'b1; need_b = 1'b1; log_r = OPA_1 & OPB_1;    end
        L_NAND:   begin need_a = 1'b1; need_b = 1'b1; log_r = ~(OPA_1 & OPB_1); end
        L_OR:     begin need_a = 1'b1; need_b = 1'b1; log_r = OPA_1 | OPB_1;    end
        L_NOR:    begin need_a = 1'b1; need_b = 1'b1; log_r = ~(OPA_1 | OPB_1); end
        L_XOR:    begin need_a = 1'b1; need_b = 1'b1; log_r = OPA_1 ^ OPB_1;    end
        L_XNOR:   begin need_a = 1'b1; need_b = 1'b1; log_r = ~(OPA_1 ^ OPB_1); end
        L_NOT_A:  begin need_a = 1'b1; log_r = ~OPA_1;      end
        L_NOT_B:  begin need_b = 1'b1; log_r = ~OPB_1;      end
        L_SHR1_A: begin need_a = 1'b1; log_r = OPA_1 >> 1; end
        L_SHL1_A: begin need_a = 1'b1; log_r = OPA_1 << 1; end
        L_SHR1_B: begin need_b = 1'b1; log_r = OPB_1 >> 1; end
        L_SHL1_B: begin need_b = 1'b1; log_r = OPB_1 << 1; end
        L_ROL, L_ROR: begin
          need_a  = 1'b1; need_b = 1'b1;
          rot_err = ((OPB_1 >> SHW) != '0);
          log_r   = (CMD == L_ROL) ? rol_r : ror_r;
        end
        default: bad_cmd = 1'b1;
      endcase
      res_d = RW'(log_r);
    end

    err_d = bad_cmd | rot_err | (INP_VALID == 2'b00) |
            (need_a & ~INP_VALID[0]) | (need_b & ~INP_VALID[1]);

    // An error suppresses every other output.
    if (err_d) begin
      res_d   = '0;
      cout_d  = 1'b0;
      oflow_d = 1'b0;
      g_d     = 1'b0;
      e_d     = 1'b0;
      l_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      err_q   <= 1'b0;
    end else if (CE) begin
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
      err_q   <= err_d;
    end
  end

  assign RES   = res_q;
  assign COUT  = cout_q;
  assign OFLOW = oflow_q;
  assign G     = g_q;
  assign E     = e_q;
  assign L     = l_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_alu_design.sv
// Directed and random checks of alu_design against an arithmetic reference model.
module tb_alu_design;

  typedef struct packed {
    logic [16:0] res;
    logic        cout;
    logic        oflow;
    logic        g;
    logic        e;
    logic        l;
    logic        err;
  } out_t;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic        MODE;
  logic [3:0]  CMD;
  logic [1:0]  INP_VALID;
  logic [7:0]  OPA_1;
  logic [7:0]  OPB_1;
  logic        CIN;
  logic [16:0] RES;
  logic        COUT, OFLOW, G, E, L, ERR;

  int   n_asrt;
  int   n_fail;
  out_t exp_q;

  alu_design #(.WIDTH_O(8), .WIDTH_C(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
    .INP_VALID(INP_VALID), .OPA_1(OPA_1), .OPB_1(OPB_1), .CIN(CIN),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: integer arithmetic straight from the command table.
  function automatic out_t model(input bit mode, input int cmd, input logic [1:0] iv,
                                 input int a, input int b, input bit cin);
    out_t x;
    int   r, sa, sb, k;
    bit   na, nb, bad;
    x = '0; r = 0; na = 1'b1; nb = 1'b1; bad = 1'b0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    k  = b % 8;
    if (mode) begin
      case (cmd)
        0:  begin r = a + b; x.res = 17'(r); x.cout = (r > 255); end
        1:  begin x.res = 17'((a - b) & 'h1FF); x.oflow = (a < b); end
        2:  begin r = a + b + int'(cin); x.res = 17'(r); x.cout = (r > 255); end
        3:  begin x.res = 17'((a - b - int'(cin)) & 'h1FF); x.oflow = (a < b + int'(cin)); end
        4:  begin nb = 1'b0; x.res = 17'(a + 1); end
        5:  begin nb = 1'b0; x.res = 17'((a - 1) & 'h1FF); end
        6:  begin na = 1'b0; x.res = 17'(b + 1); end
        7:  begin na = 1'b0; x.res = 17'((b - 1) & 'h1FF); end
        8:  begin x.g = (a > b); x.e = (a == b); x.l = (a < b); end
        9:  x.res = 17'((a + 1) * (b + 1));
        10: x.res = 17'(2 * a * b);
        11, 12: begin
          r = (cmd == 11) ? sa + sb : sa - sb;
          x.res   = 17'(r);
          x.oflow = (r > 127) || (r < -128);
          x.g = (sa > sb); x.e = (sa == sb); x.l = (sa < sb);
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = ~(a & b);
        2:  r = a | b;
        3:  r = ~(a | b);
        4:  r = a ^ b;
        5:  r = ~(a ^ b);
        6:  begin nb = 1'b0; r = ~a;     end
        7:  begin na = 1'b0; r = ~b;     end
        8:  begin nb = 1'b0; r = a >> 1; end
        9:  begin nb = 1'b0; r = a << 1; end
        10: begin na = 1'b0; r = b >> 1; end
        11: begin na = 1'b0; r = b << 1; end
        12: begin bad = (b > 7); r = (a << k) | (a >> (8 - k)); end
        13: begin bad = (b > 7); r = (a >> k) | (a << (8 - k)); end
        default: bad = 1'b1;
      endcase
      x.res = 17'(r & 255);
    end
    if (bad || iv == 2'b00 || (na && !iv[0]) || (nb && !iv[1])) begin
      x = '0;
      x.err = 1'b1;
    end
    return x;
  endfunction

  task automatic check(input string tag, input out_t exp);
    out_t obs;
    obs = {RES, COUT, OFLOW, G, E, L, ERR};
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed res=%h c=%b o=%b g=%b e=%b l=%b err=%b, expected res=%h c=%b o=%b g=%b e=%b l=%b err=%b",
             tag, obs.res, obs.cout, obs.oflow, obs.g, obs.e, obs.l, obs.err,
             exp.res, exp.cout, exp.oflow, exp.g, exp.e, exp.l, exp.err);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_asrt++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic step(input string tag, input bit mode, input int cmd, input logic [1:0] iv,
                      input logic [7:0] a, input logic [7:0] b, input bit cin, input bit ce);
    MODE = mode; CMD = 4'(cmd); INP_VALID = iv;
    OPA_1 = a; OPB_1 = b; CIN = cin; CE = ce;
    @(posedge CLK);
    #1;
    if (ce) exp_q = model(mode, cmd, iv, int'(a), int'(b), cin);
    check(tag, exp_q);
  endtask

  initial begin
    n_asrt = 0; n_fail = 0; exp_q = '0;
    RST = 1'b1; CE = 1'b1; MODE = 1'b1; CMD = 4'd0; INP_VALID = 2'b11;
    OPA_1 = 8'd5; OPB_1 = 8'd6; CIN = 1'b0;
    #1;
    check("reset_now", '0);
    @(posedge CLK); #1;
    check("reset_held", '0);
    RST = 1'b0;

    // Arithmetic
    step("add_max", 1, 0, 2'b11, 8'd255, 8'd255, 0, 1);
    chk("add_max_res", 32'(RES), 32'd510);
    chk("add_max_cout", 32'(COUT), 32'd1);
    step("sub_neg", 1, 1, 2'b11, 8'd20, 8'd40, 0, 1);
    chk("sub_neg_res", 32'(RES), 32'h1EC);
    chk("sub_neg_oflow", 32'(OFLOW), 32'd1);
    step("add_cin", 1, 2, 2'b11, 8'd10, 8'd20, 1, 1);
    chk("add_cin_res", 32'(RES), 32'd31);
    step("sub_cin", 1, 3, 2'b11, 8'd20, 8'd20, 1, 1);
    step("dec_a0", 1, 5, 2'b01, 8'd0, 8'd0, 0, 1);
    chk("dec_a0_res", 32'(RES), 32'h1FF);

    // Multiply
    step("mul_inc_a", 1, 9, 2'b11, 8'd7, 8'd5, 0, 1);
    chk("mul_inc_a_res", 32'(RES), 32'd48);
    step("mul_inc_b", 1, 9, 2'b11, 8'd128, 8'd5, 0, 1);
    chk("mul_inc_b_res", 32'(RES), 32'd774);
    step("mul_shl_a", 1, 10, 2'b11, 8'd4, 8'd5, 0, 1);
    chk("mul_shl_a_res", 32'(RES), 32'd40);
    step("mul_shl_b", 1, 10, 2'b11, 8'd128, 8'd5, 0, 1);
    chk("mul_shl_b_res", 32'(RES), 32'd1280);

    // Signed
    step("sadd_ovf", 1, 11, 2'b11, 8'd127, 8'd1, 0, 1);
    chk("sadd_ovf_res", 32'(RES), 32'd128);
    chk("sadd_ovf_flags", 32'({OFLOW, G}), 32'b11);
    step("sadd_neg_ovf", 1, 11, 2'b11, 8'h88, 8'hE7, 0, 1);
    chk("sadd_neg_ovf_o", 32'(OFLOW), 32'd1);
    step("ssub", 1, 12, 2'b11, 8'hE2, 8'hE7, 0, 1);
    chk("ssub_res", 32'(RES), 32'h1FFFB);
    chk("ssub_flags", 32'({OFLOW, L}), 32'b01);
    step("cmp_eq", 1, 8, 2'b11, 8'd23, 8'd23, 0, 1);
    chk("cmp_eq_flags", 32'({RES, E}), 32'd1);

    // Logic
    step("and", 0, 0, 2'b11, 8'hAA, 8'hCC, 0, 1);
    chk("and_res", 32'(RES), 32'h88);
    step("nand", 0, 1, 2'b11, 8'hAA, 8'hCC, 0, 1);
    chk("nand_res", 32'(RES), 32'h77);
    step("xor", 0, 4, 2'b11, 8'hAA, 8'hCC, 0, 1);
    chk("xor_res", 32'(RES), 32'h66);
    step("shl1_a", 0, 9, 2'b01, 8'h01, 8'h00, 0, 1);
    chk("shl1_a_res", 32'(RES), 32'h02);
    step("rol", 0, 12, 2'b11, 8'h2B, 8'h01, 0, 1);
    chk("rol_res", 32'(RES), 32'h56);
    step("ror", 0, 13, 2'b11, 8'h7D, 8'h04, 0, 1);
    chk("ror_res", 32'(RES), 32'hD7);
    step("rol_err", 0, 12, 2'b11, 8'h2B, 8'h11, 0, 1);
    chk("rol_err_flag", 32'({RES, ERR}), 32'd1);
    step("ror_err", 0, 13, 2'b11, 8'h7D, 8'h09, 0, 1);
    chk("ror_err_flag", 32'({RES, ERR}), 32'd1);

    // Validity, illegal commands, enable
    step("add_a_only", 1, 0, 2'b01, 8'd3, 8'd4, 0, 1);
    chk("add_a_only_err", 32'(ERR), 32'd1);
    step("inc_b_only", 1, 6, 2'b10, 8'd0, 8'hCC, 0, 1);
    chk("inc_b_only_res", 32'({RES, ERR}), 32'({17'hCD, 1'b0}));
    step("iv_none", 0, 6, 2'b00, 8'd1, 8'd1, 0, 1);
    step("arith_illegal", 1, 14, 2'b11, 8'd1, 8'd1, 0, 1);
    step("logic_illegal", 0, 15, 2'b11, 8'd1, 8'd1, 0, 1);
    step("pre_hold", 1, 0, 2'b11, 8'd100, 8'd50, 0, 1);
    step("ce_hold1", 1, 1, 2'b11, 8'd1, 8'd2, 0, 0);
    step("ce_hold2", 0, 15, 2'b00, 8'd9, 8'd9, 1, 0);
    chk("ce_hold_res", 32'(RES), 32'd150);

    // Asynchronous reset between edges, held across an edge, then released
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("async_rst", '0);
    MODE = 1'b1; CMD = 4'd0; INP_VALID = 2'b11; OPA_1 = 8'd3; OPB_1 = 8'd4; CE = 1'b1;
    @(posedge CLK); #1;
    check("rst_held_edge", '0);
    exp_q = '0;
    RST = 1'b0;
    @(posedge CLK); #1;
    exp_q = model(1'b1, 0, 2'b11, 3, 4, 1'b0);
    check("rst_release", exp_q);
    chk("rst_release_res", 32'(RES), 32'd7);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] riv;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if ($urandom_range(2, 0) == 0) rb = rb & 8'h07;
      riv = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b11;
      step("random", 1'($urandom), int'($urandom_range(15, 0)), riv, ra, rb,
           1'($urandom), ($urandom_range(7, 0) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
